// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/forward scheduler for the F/D/E/M/W pipeline, driven by a
// registered E/M/W shadow. Define HAZARD_MDU_STALL_EN to add the mult/div busy interlock.
module hazard_ctrl #(
  parameter int RW  = 5,
  parameter int ICW = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [ICW-1:0] ic_d,
  input  logic [RW-1:0]  a1_d,
  input  logic [RW-1:0]  a2_d,
  input  logic [RW-1:0]  a3_d,
`ifdef HAZARD_MDU_STALL_EN
  input  logic           md_start,
  input  logic           md_div,
  input  logic           md_use_d,
`endif
  output logic           stall,
  output logic [1:0]     fwd_rs_d,
  output logic [1:0]     fwd_rt_d,
  output logic [1:0]     fwd_rs_e,
  output logic [1:0]     fwd_rt_e,
  output logic [1:0]     fwd_rt_m
);

  localparam logic [ICW-1:0] IC_NOP   = ICW'(0);
  localparam logic [ICW-1:0] IC_CAL_R = ICW'(1);
  localparam logic [ICW-1:0] IC_CAL_I = ICW'(2);
  localparam logic [ICW-1:0] IC_LOAD  = ICW'(3);
  localparam logic [ICW-1:0] IC_STORE = ICW'(4);
  localparam logic [ICW-1:0] IC_B     = ICW'(5);
  localparam logic [ICW-1:0] IC_J     = ICW'(6);
  localparam logic [ICW-1:0] IC_JR    = ICW'(7);
  localparam logic [ICW-1:0] IC_JAL   = ICW'(8);
  localparam logic [ICW-1:0] IC_JALR  = ICW'(9);

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_M   = 2'd1;
  localparam logic [1:0] FWD_W   = 2'd2;
  localparam logic [1:0] FWD_PC8 = 2'd3;

  // E stage keeps the full record; M and W keep only what the selects consume
  // (W Tnew is always zero, so it is not stored).
  logic [ICW-1:0] e_ic_reg, e_ic_next;
  logic [RW-1:0]  e_a1_reg, e_a1_next;
  logic [RW-1:0]  e_a2_reg, e_a2_next;
  logic [RW-1:0]  e_a3_reg, e_a3_next;
  logic [1:0]     e_tnew_reg, e_tnew_next;
  logic [RW-1:0]  m_a2_reg, m_a3_reg;
  logic [1:0]     m_tnew_reg, m_tnew_next;
  logic [RW-1:0]  w_a3_reg;

  logic [1:0]         use_src;
  logic [1:0][1:0]    tuse_src;
  logic [1:0]         tnew_d;
  logic               writes_d;
  logic [1:0][RW-1:0] src_d;
  logic [1:0][RW-1:0] src_e;
  logic [1:0]         haz;
  logic [1:0][1:0]    fwd_d;
  logic [1:0][1:0]    fwd_e;
  logic               e_link;
  logic               md_stall;

  // Per-class source usage, Tuse and the Tnew the instruction carries into E.
  always_comb begin
    use_src     = 2'b00;
    tuse_src[0] = 2'd0;
    tuse_src[1] = 2'd0;
    tnew_d      = 2'd0;
    writes_d    = 1'b0;
    case (ic_d)
      IC_CAL_R: begin
        use_src     = 2'b11;
        tuse_src[0] = 2'd1;
        tuse_src[1] = 2'd1;
        tnew_d      = 2'd1;
        writes_d    = 1'b1;
      end
      IC_CAL_I: begin
        use_src     = 2'b01;
        tuse_src[0] = 2'd1;
        tnew_d      = 2'd1;
        writes_d    = 1'b1;
      end
      IC_LOAD: begin
        use_src     = 2'b01;
        tuse_src[0] = 2'd1;
        tnew_d      = 2'd2;
        writes_d    = 1'b1;
      end
      IC_STORE: begin
        use_src     = 2'b11;
        tuse_src[0] = 2'd1;
        tuse_src[1] = 2'd2;
      end
      IC_B: begin
        use_src     = 2'b11;
      end
      IC_JR: begin
        use_src     = 2'b01;
      end
      IC_JAL: begin
        writes_d    = 1'b1;
      end
      IC_JALR: begin
        use_src     = 2'b01;
        writes_d    = 1'b1;
      end
      IC_NOP, IC_J: begin
        use_src     = 2'b00;
      end
      default: begin
        use_src     = 2'b00;
      end
    endcase
  end

  assign src_d[0] = a1_d;
  assign src_d[1] = a2_d;
  assign src_e[0] = e_a1_reg;
  assign src_e[1] = e_a2_reg;
  assign e_link   = (e_ic_reg == IC_JAL) || (e_ic_reg == IC_JALR);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic live_d, live_e;
      logic hit_e_d, hit_m_d, hit_w_d;
      logic hit_m_e, hit_w_e;

      assign live_d  = (src_d[gi] != '0);
      assign live_e  = (src_e[gi] != '0);
      assign hit_e_d = live_d && (e_a3_reg == src_d[gi]);
      assign hit_m_d = live_d && (m_a3_reg == src_d[gi]);
      assign hit_w_d = live_d && (w_a3_reg == src_d[gi]);
      assign hit_m_e = live_e && (m_a3_reg == src_e[gi]);
      assign hit_w_e = live_e && (w_a3_reg == src_e[gi]);

      // A producer that is still too far from its result for this consumer.
      assign haz[gi] = use_src[gi] &&
                       ((hit_e_d && (e_tnew_reg > tuse_src[gi])) ||
                        (hit_m_d && (m_tnew_reg > tuse_src[gi])));

      assign fwd_d[gi] = (hit_e_d && e_link && (e_tnew_reg == 2'd0)) ? FWD_PC8 :
                         (hit_m_d && (m_tnew_reg == 2'd0))           ? FWD_M   :
                         hit_w_d                                      ? FWD_W   :
                                                                        FWD_RF;

      assign fwd_e[gi] = (hit_m_e && (m_tnew_reg == 2'd0)) ? FWD_M :
                         hit_w_e                            ? FWD_W :
                                                              FWD_RF;
    end
  endgenerate

`ifdef HAZARD_MDU_STALL_EN
  logic [3:0] busy_reg, busy_next;

  always_comb begin
    busy_next = busy_reg;
    if (md_start) begin
      busy_next = md_div ? 4'd10 : 4'd5;
    end else if (busy_reg != 4'd0) begin
      busy_next = busy_reg - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg <= 4'd0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign md_stall = reset_n && md_use_d && (md_start || (busy_reg != 4'd0));
`else
  assign md_stall = 1'b0;
`endif

  assign stall    = (|haz) || md_stall;
  assign fwd_rs_d = fwd_d[0];
  assign fwd_rt_d = fwd_d[1];
  assign fwd_rs_e = fwd_e[0];
  assign fwd_rt_e = fwd_e[1];
  assign fwd_rt_m = ((m_a2_reg != '0) && (w_a3_reg == m_a2_reg)) ? FWD_W : FWD_RF;

  // Non-writing classes enter E with A3 cleared so they can never match.
  always_comb begin
    e_ic_next   = ic_d;
    e_a1_next   = a1_d;
    e_a2_next   = a2_d;
    e_a3_next   = writes_d ? a3_d : '0;
    e_tnew_next = tnew_d;
    if (stall) begin
      e_ic_next   = '0;
      e_a1_next   = '0;
      e_a2_next   = '0;
      e_a3_next   = '0;
      e_tnew_next = 2'd0;
    end
  end

  assign m_tnew_next = (e_tnew_reg != 2'd0) ? (e_tnew_reg - 2'd1) : 2'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_ic_reg   <= '0;
      e_a1_reg   <= '0;
      e_a2_reg   <= '0;
      e_a3_reg   <= '0;
      e_tnew_reg <= 2'd0;
      m_a2_reg   <= '0;
      m_a3_reg   <= '0;
      m_tnew_reg <= 2'd0;
      w_a3_reg   <= '0;
    end else begin
      e_ic_reg   <= e_ic_next;
      e_a1_reg   <= e_a1_next;
      e_a2_reg   <= e_a2_next;
      e_a3_reg   <= e_a3_next;
      e_tnew_reg <= e_tnew_next;
      m_a2_reg   <= e_a2_reg;
      m_a3_reg   <= e_a3_reg;
      m_tnew_reg <= m_tnew_next;
      w_a3_reg   <= m_a3_reg;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each row drives the D stage, pushes the
// hand-derived expected {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}.
`timescale 1ns/1ps
module tb_hazard_ctrl;
  localparam logic [3:0] NOP = 4'd0, CALR = 4'd1, CALI = 4'd2, LOAD = 4'd3;
  localparam logic [3:0] STORE = 4'd4, BR = 4'd5, JR = 4'd7, JAL = 4'd8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] ic_d;
  logic [4:0] a1_d, a2_d, a3_d;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

  typedef struct {
    logic [3:0]  ic;
    logic [4:0]  a1, a2, a3;
    logic [10:0] exp;
  } row_t;

  logic [10:0] exp_q[$];
  row_t        rows[$];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RW(5), .ICW(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_d(ic_d), .a1_d(a1_d), .a2_d(a2_d), .a3_d(a3_d),
    .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
  );

  function automatic logic [10:0] mk(input logic s, input logic [1:0] rsd, input logic [1:0] rtd,
                                     input logic [1:0] rse, input logic [1:0] rte, input logic [1:0] rtm);
    return {s, rsd, rtd, rse, rte, rtm};
  endfunction

  function automatic logic [10:0] outs();
    return {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
  endfunction

  function automatic row_t row(input logic [3:0] ic, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] a3, input logic [10:0] e);
    row_t t;
    t.ic = ic; t.a1 = a1; t.a2 = a2; t.a3 = a3; t.exp = e;
    return t;
  endfunction

  task automatic set_d(input logic [3:0] ic, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    ic_d = ic; a1_d = a1; a2_d = a2; a3_d = a3;
  endtask

  task automatic apply(input row_t t);
    @(posedge clk);
    #1;
    set_d(t.ic, t.a1, t.a2, t.a3);
    exp_q.push_back(t.exp);
  endtask

  task automatic flush();
    repeat (3) begin
      @(posedge clk);
      #1;
      set_d(NOP, 5'd0, 5'd0, 5'd0);
    end
  endtask

  task automatic test_reset();
    logic [10:0] e, got;
    @(posedge clk); #1;
    set_d(CALR, 5'd8, 5'd10, 5'd9);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL reset_hold got=%b exp=%b", got, e); end
    else $display("[TB] reset_hold outs=%b", got);
    @(posedge clk); #1;
    set_d(BR, 5'd8, 5'd0, 5'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    e = exp_q.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL reset_edge got=%b exp=%b", got, e); end
    else $display("[TB] reset_edge outs=%b", got);
    reset_n = 1'b1;
  endtask

  task automatic test_load_use();
    logic [10:0] e, got;
    flush();
    rows = {};
    rows.push_back(row(LOAD, 5'd2, 5'd0, 5'd8, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(CALR, 5'd8, 5'd10, 5'd9, mk(1, 0, 0, 0, 0, 0)));
    rows.push_back(row(CALR, 5'd8, 5'd10, 5'd9, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(NOP, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 2, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e); end
      else $display("[TB] load_use[%0d] outs=%b", i, got);
    end
  endtask

  task automatic test_load_branch();
    logic [10:0] e, got;
    flush();
    rows = {};
    rows.push_back(row(LOAD, 5'd2, 5'd0, 5'd6, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(BR, 5'd6, 5'd0, 5'd0, mk(1, 0, 0, 0, 0, 0)));
    rows.push_back(row(BR, 5'd6, 5'd0, 5'd0, mk(1, 0, 0, 0, 0, 0)));
    rows.push_back(row(BR, 5'd6, 5'd0, 5'd0, mk(0, 2, 0, 0, 0, 0)));
    rows.push_back(row(NOP, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL load_branch[%0d] got=%b exp=%b", i, got, e); end
      else $display("[TB] load_branch[%0d] outs=%b", i, got);
    end
  endtask

  task automatic test_alu_branch();
    logic [10:0] e, got;
    flush();
    rows = {};
    rows.push_back(row(CALR, 5'd1, 5'd2, 5'd3, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(BR, 5'd3, 5'd4, 5'd0, mk(1, 0, 0, 0, 0, 0)));
    rows.push_back(row(BR, 5'd3, 5'd4, 5'd0, mk(0, 1, 0, 0, 0, 0)));
    rows.push_back(row(NOP, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 2, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL alu_branch[%0d] got=%b exp=%b", i, got, e); end
      else $display("[TB] alu_branch[%0d] outs=%b", i, got);
    end
  endtask

  task automatic test_jal_link();
    logic [10:0] e, got;
    flush();
    rows = {};
    rows.push_back(row(JAL, 5'd0, 5'd0, 5'd31, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(JR, 5'd31, 5'd0, 5'd0, mk(0, 3, 0, 0, 0, 0)));
    rows.push_back(row(NOP, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 1, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL jal_link[%0d] got=%b exp=%b", i, got, e); end
      else $display("[TB] jal_link[%0d] outs=%b", i, got);
    end
  endtask

  task automatic test_store_data();
    logic [10:0] e, got;
    flush();
    rows = {};
    rows.push_back(row(LOAD, 5'd2, 5'd0, 5'd5, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(STORE, 5'd6, 5'd5, 5'd0, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(NOP, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(NOP, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 0, 2)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL store_data[%0d] got=%b exp=%b", i, got, e); end
      else $display("[TB] store_data[%0d] outs=%b", i, got);
    end
  endtask

  task automatic test_zero_priority();
    logic [10:0] e, got;
    flush();
    rows = {};
    rows.push_back(row(CALR, 5'd1, 5'd2, 5'd0, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(BR, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(CALR, 5'd1, 5'd2, 5'd7, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(CALI, 5'd0, 5'd0, 5'd7, mk(0, 0, 0, 0, 0, 0)));
    rows.push_back(row(CALR, 5'd7, 5'd0, 5'd8, mk(0, 1, 0, 0, 0, 0)));
    rows.push_back(row(NOP, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 1, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL zero_priority[%0d] got=%b exp=%b", i, got, e); end
      else $display("[TB] zero_priority[%0d] outs=%b", i, got);
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e, got;
    flush();
    apply(row(LOAD, 5'd2, 5'd0, 5'd8, mk(0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    e = exp_q.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL areset_lw got=%b exp=%b", got, e); end
    else $display("[TB] areset_lw outs=%b", got);
    apply(row(CALR, 5'd8, 5'd10, 5'd9, mk(1, 0, 0, 0, 0, 0)));
    @(negedge clk);
    e = exp_q.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL areset_pre got=%b exp=%b", got, e); end
    else $display("[TB] areset_pre outs=%b", got);
    #2 reset_n = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL areset_now got=%b exp=%b", got, e); end
    else $display("[TB] areset_now outs=%b", got);
    @(posedge clk);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL areset_edge got=%b exp=%b", got, e); end
    else $display("[TB] areset_edge outs=%b", got);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); got = outs(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL areset_release got=%b exp=%b", got, e); end
    else $display("[TB] areset_release outs=%b", got);
    rows = {};
    rows.push_back(row(BR, 5'd9, 5'd0, 5'd0, mk(1, 0, 0, 0, 0, 0)));
    rows.push_back(row(BR, 5'd9, 5'd0, 5'd0, mk(0, 1, 0, 0, 0, 0)));
    rows.push_back(row(NOP, 5'd0, 5'd0, 5'd0, mk(0, 0, 0, 2, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = outs(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL areset_after[%0d] got=%b exp=%b", i, got, e); end
      else $display("[TB] areset_after[%0d] outs=%b", i, got);
    end
  endtask

  initial begin
    set_d(NOP, 5'd0, 5'd0, 5'd0);
    reset_n = 1'b0;
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_jal_link();
    test_store_data();
    test_zero_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
